// File: rtl/canny_window_gen_if.sv
// Pixel-stream input and 3x3 window output bundle for the canny window generator.
// The producer/consumer side uses master; the window generator uses slave.
interface canny_window_gen_if #(
   parameter int DATA_W  = 16,
   parameter int COORD_W = 10
);
   logic               start;
   logic               pix_valid;
   logic [DATA_W-1:0]  pix_in;
   logic [DATA_W-1:0]  im11, im12, im13;
   logic [DATA_W-1:0]  im21, im22, im23;
   logic [DATA_W-1:0]  im31, im32, im33;
   logic               win_valid;
   logic [COORD_W-1:0] win_x;
   logic [COORD_W-1:0] win_y;
   logic               frame_done;

   modport master (
      output start, pix_valid, pix_in,
      input  im11, im12, im13, im21, im22, im23, im31, im32, im33,
      input  win_valid, win_x, win_y, frame_done
   );

   modport slave (
      input  start, pix_valid, pix_in,
      output im11, im12, im13, im21, im22, im23, im31, im32, im33,
      output win_valid, win_x, win_y, frame_done
   );
endinterface

// File: rtl/canny_window_gen.sv
// 3x3 raster neighbourhood generator with two line buffers; only interior windows are flagged.
// Latency 1 cycle; no backpressure, idle cycles hold the taps and clear win_valid.
module canny_window_gen #(
   parameter int DATA_W  = 16,
   parameter int IMG_W   = 768,
   parameter int IMG_H   = 768,
   parameter int COORD_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   canny_window_gen_if.slave win
);
   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [COORD_W-1:0] LAST_C = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] LAST_R = COORD_W'(IMG_H - 1);
   localparam logic [COORD_W-1:0] TWO    = COORD_W'(2);
   localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];

   logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
   logic [COORD_W-1:0] cur_c, cur_r;
   logic [AW-1:0]      addr;
   logic [DATA_W-1:0]  lb0_rd, lb1_rd;

   // Tap index 2 is column c, index 0 is column c-2.
   logic [2:0][DATA_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;

   logic               win_valid_q, win_valid_d;
   logic               frame_done_q, frame_done_d;
   logic [COORD_W-1:0] win_x_q, win_x_d, win_y_q, win_y_d;

   // A start pulse relocates the current pixel to (0,0) of a fresh frame.
   assign cur_c  = win.start ? '0 : col_q;
   assign cur_r  = win.start ? '0 : row_q;
   assign addr   = cur_c[AW-1:0];
   assign lb0_rd = lb0[addr];
   assign lb1_rd = lb1[addr];

   always_ff @(posedge clk) begin
      if (win.pix_valid) begin
         lb1[addr] <= lb0_rd;
         lb0[addr] <= win.pix_in;
      end
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      top_d        = top_q;
      mid_d        = mid_q;
      bot_d        = bot_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      win_x_d      = win_x_q;
      win_y_d      = win_y_q;

      if (win.start) begin
         col_d = '0;
         row_d = '0;
      end

      if (win.pix_valid) begin
         if (cur_c == LAST_C) begin
            col_d = '0;
            row_d = (cur_r == LAST_R) ? '0 : cur_r + ONE;
         end else begin
            col_d = cur_c + ONE;
            row_d = cur_r;
         end

         top_d = {lb1_rd, top_q[2:1]};
         mid_d = {lb0_rd, mid_q[2:1]};
         bot_d = {win.pix_in, bot_q[2:1]};

         // Column gating also guarantees the window never straddles a line wrap.
         if (cur_r >= TWO && cur_c >= TWO) begin
            win_valid_d  = 1'b1;
            win_x_d      = cur_c - ONE;
            win_y_d      = cur_r - ONE;
            frame_done_d = (cur_c == LAST_C) && (cur_r == LAST_R);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         top_q        <= '0;
         mid_q        <= '0;
         bot_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_x_q      <= '0;
         win_y_q      <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         top_q        <= top_d;
         mid_q        <= mid_d;
         bot_q        <= bot_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
      end
   end

   assign win.im11       = top_q[0];
   assign win.im12       = top_q[1];
   assign win.im13       = top_q[2];
   assign win.im21       = mid_q[0];
   assign win.im22       = mid_q[1];
   assign win.im23       = mid_q[2];
   assign win.im31       = bot_q[0];
   assign win.im32       = bot_q[1];
   assign win.im33       = bot_q[2];
   assign win.win_valid  = win_valid_q;
   assign win.win_x      = win_x_q;
   assign win.win_y      = win_y_q;
   assign win.frame_done = frame_done_q;
endmodule

// File: tb/tb_canny_window_gen.sv
// Directed bench for canny_window_gen on a 5x4 image; pixel value = base + 16*r + c.
// The zero-column scenario uses all-ones pixels with column 2 forced to zero.
module tb_canny_window_gen;
   localparam int DW = 16;
   localparam int W  = 5;
   localparam int H  = 4;
   localparam int CW = 10;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   canny_window_gen_if #(.DATA_W(DW), .COORD_W(CW)) ifc ();

   canny_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .win   (ifc.slave)
   );

   int total = 0;
   int bad   = 0;

   wire [9*DW-1:0] win_obs = {ifc.im11, ifc.im12, ifc.im13,
                              ifc.im21, ifc.im22, ifc.im23,
                              ifc.im31, ifc.im32, ifc.im33};

   function automatic logic [DW-1:0] pix_val(input logic [DW-1:0] base, input bit zc,
                                             input int r, input int c);
      if (zc) return (c == 2) ? 16'h0000 : 16'hFFFF;
      return base + DW'(16 * r + c);
   endfunction

   function automatic logic [9*DW-1:0] exp_win(input logic [DW-1:0] base, input bit zc,
                                               input int r, input int c);
      logic [9*DW-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w = {w[8*DW-1:0], pix_val(base, zc, r - 2 + i, c - 2 + j)};
      return w;
   endfunction

   task automatic send(input logic [DW-1:0] px, input logic v, input logic st);
      ifc.pix_in    = px;
      ifc.pix_valid = v;
      ifc.start     = st;
      @(posedge clk);
      #1;
      ifc.pix_valid = 1'b0;
      ifc.start     = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      send(16'hABCD, 1'b1, 1'b0);
      send(16'h1234, 1'b1, 1'b0);
      total++;
      if (win_obs !== '0 || ifc.win_valid !== 1'b0 || ifc.frame_done !== 1'b0 ||
          ifc.win_x !== '0 || ifc.win_y !== '0) begin
         bad++;
         $display("FAIL reset_outputs: taps=%h vld=%b done=%b x=%0d y=%0d, required all zero",
                  win_obs, ifc.win_valid, ifc.frame_done, ifc.win_x, ifc.win_y);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream;
      int nwin = 0, ndone = 0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
         send(pix_val(16'h0, 1'b0, r, c), 1'b1, 1'b0);
         nwin += int'(ifc.win_valid); ndone += int'(ifc.frame_done);
         total++;
         if (ifc.win_valid !== (r >= 2 && c >= 2)) begin
            bad++; $display("FAIL stream_vld r=%0d c=%0d got=%b", r, c, ifc.win_valid);
         end
         if (r >= 2 && c >= 2) begin
            total++;
            if (win_obs !== exp_win(16'h0, 1'b0, r, c)) begin
               bad++; $display("FAIL stream_taps r=%0d c=%0d got=%h exp=%h", r, c, win_obs, exp_win(16'h0, 1'b0, r, c));
            end
            total++;
            if (ifc.win_x !== CW'(c - 1) || ifc.win_y !== CW'(r - 1)) begin
               bad++; $display("FAIL stream_xy got=%0d,%0d exp=%0d,%0d", ifc.win_x, ifc.win_y, c - 1, r - 1);
            end
            total++;
            if (ifc.frame_done !== (r == H - 1 && c == W - 1)) begin
               bad++; $display("FAIL stream_done r=%0d c=%0d got=%b", r, c, ifc.frame_done);
            end
         end
      end
      total++;
      if (nwin != 6) begin bad++; $display("FAIL stream_count got=%0d exp=6", nwin); end
      total++;
      if (ndone != 1) begin bad++; $display("FAIL stream_done_count got=%0d exp=1", ndone); end
   endtask

   task automatic test_gaps;
      int nwin = 0;
      logic [9*DW-1:0] held;
      logic [CW-1:0] hx, hy;
      held = win_obs; hx = ifc.win_x; hy = ifc.win_y;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
         int idle = int'($urandom_range(0, 2));
         for (int k = 0; k < idle; k++) begin
            send(16'hDEAD, 1'b0, 1'b0);
            total++;
            if (ifc.win_valid !== 1'b0 || ifc.frame_done !== 1'b0 || win_obs !== held ||
                ifc.win_x !== hx || ifc.win_y !== hy) begin
               bad++; $display("FAIL gap_hold r=%0d c=%0d vld=%b taps=%h exp=%h", r, c, ifc.win_valid, win_obs, held);
            end
         end
         send(pix_val(16'h0, 1'b0, r, c), 1'b1, 1'b0);
         held = win_obs; hx = ifc.win_x; hy = ifc.win_y;
         nwin += int'(ifc.win_valid);
         total++;
         if (ifc.win_valid !== (r >= 2 && c >= 2)) begin
            bad++; $display("FAIL gap_vld r=%0d c=%0d got=%b", r, c, ifc.win_valid);
         end
         if (r >= 2 && c >= 2) begin
            total++;
            if (win_obs !== exp_win(16'h0, 1'b0, r, c) || ifc.win_x !== CW'(c - 1) || ifc.win_y !== CW'(r - 1)) begin
               bad++; $display("FAIL gap_taps r=%0d c=%0d got=%h x=%0d y=%0d", r, c, win_obs, ifc.win_x, ifc.win_y);
            end
         end
      end
      total++;
      if (nwin != 6) begin bad++; $display("FAIL gap_count got=%0d exp=6", nwin); end
   endtask

   task automatic test_back_to_back;
      int nwin = 0, ndone = 0;
      logic [DW-1:0] base;
      for (int f = 0; f < 2; f++) begin
         base = (f == 0) ? 16'h0100 : 16'h0200;
         for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
            send(pix_val(base, 1'b0, r, c), 1'b1, 1'b0);
            nwin += int'(ifc.win_valid); ndone += int'(ifc.frame_done);
            if (r >= 2 && c >= 2) begin
               total++;
               if (ifc.win_valid !== 1'b1 || win_obs !== exp_win(base, 1'b0, r, c)) begin
                  bad++; $display("FAIL b2b_taps f=%0d r=%0d c=%0d vld=%b got=%h exp=%h", f, r, c, ifc.win_valid, win_obs, exp_win(base, 1'b0, r, c));
               end
            end
         end
      end
      total++;
      if (nwin != 12) begin bad++; $display("FAIL b2b_count got=%0d exp=12", nwin); end
      total++;
      if (ndone != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
   endtask

   task automatic test_start_truncate;
      int nwin = 0, ndone = 0;
      for (int i = 0; i < 13; i++) begin
         send(pix_val(16'h0300, 1'b0, i / W, i % W), 1'b1, 1'b0);
         ndone += int'(ifc.frame_done);
      end
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
         send(pix_val(16'h0400, 1'b0, r, c), 1'b1, (r == 0 && c == 0));
         nwin += int'(ifc.win_valid); ndone += int'(ifc.frame_done);
         total++;
         if (ifc.win_valid !== (r >= 2 && c >= 2)) begin
            bad++; $display("FAIL start_vld r=%0d c=%0d got=%b", r, c, ifc.win_valid);
         end
         if (r >= 2 && c >= 2) begin
            total++;
            if (win_obs !== exp_win(16'h0400, 1'b0, r, c) || ifc.win_x !== CW'(c - 1) || ifc.win_y !== CW'(r - 1)) begin
               bad++; $display("FAIL start_taps r=%0d c=%0d got=%h exp=%h", r, c, win_obs, exp_win(16'h0400, 1'b0, r, c));
            end
         end
      end
      total++;
      if (nwin != 6) begin bad++; $display("FAIL start_count got=%0d exp=6", nwin); end
      total++;
      if (ndone != 1) begin bad++; $display("FAIL start_done_count got=%0d exp=1", ndone); end
   endtask

   task automatic test_start_idle;
      int nwin = 0;
      for (int i = 0; i < 14; i++) send(pix_val(16'h0500, 1'b0, i / W, i % W), 1'b1, 1'b0);
      send(16'h0, 1'b0, 1'b1);
      total++;
      if (ifc.win_valid !== 1'b0) begin bad++; $display("FAIL start_idle_vld got=%b exp=0", ifc.win_valid); end
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
         send(pix_val(16'h0600, 1'b0, r, c), 1'b1, 1'b0);
         nwin += int'(ifc.win_valid);
         if (r >= 2 && c >= 2) begin
            total++;
            if (ifc.win_valid !== 1'b1 || win_obs !== exp_win(16'h0600, 1'b0, r, c)) begin
               bad++; $display("FAIL start_idle_taps r=%0d c=%0d got=%h exp=%h", r, c, win_obs, exp_win(16'h0600, 1'b0, r, c));
            end
         end
      end
      total++;
      if (nwin != 6) begin bad++; $display("FAIL start_idle_count got=%0d exp=6", nwin); end
   endtask

   task automatic test_reset_mid;
      int nwin = 0, ndone = 0;
      for (int i = 0; i < 14; i++) send(pix_val(16'h0700, 1'b0, i / W, i % W), 1'b1, 1'b0);
      reset = 1'b1;
      send(16'h0, 1'b0, 1'b0);
      reset = 1'b0;
      total++;
      if (win_obs !== '0 || ifc.win_valid !== 1'b0 || ifc.frame_done !== 1'b0 ||
          ifc.win_x !== '0 || ifc.win_y !== '0) begin
         bad++; $display("FAIL reset_mid_outputs: taps=%h vld=%b x=%0d y=%0d, required zero", win_obs, ifc.win_valid, ifc.win_x, ifc.win_y);
      end
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
         send(pix_val(16'h0800, 1'b0, r, c), 1'b1, 1'b0);
         nwin += int'(ifc.win_valid); ndone += int'(ifc.frame_done);
         total++;
         if (ifc.win_valid !== (r >= 2 && c >= 2)) begin
            bad++; $display("FAIL reset_mid_vld r=%0d c=%0d got=%b", r, c, ifc.win_valid);
         end
         if (r >= 2 && c >= 2) begin
            total++;
            if (win_obs !== exp_win(16'h0800, 1'b0, r, c) || ifc.win_x !== CW'(c - 1) || ifc.win_y !== CW'(r - 1)) begin
               bad++; $display("FAIL reset_mid_taps r=%0d c=%0d got=%h exp=%h", r, c, win_obs, exp_win(16'h0800, 1'b0, r, c));
            end
         end
      end
      total++;
      if (nwin != 6 || ndone != 1) begin bad++; $display("FAIL reset_mid_counts win=%0d done=%0d exp=6,1", nwin, ndone); end
   endtask

   task automatic test_zero_column;
      int max_x = 0, max_y = 0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
         send(pix_val(16'h0, 1'b1, r, c), 1'b1, 1'b0);
         if (ifc.win_valid === 1'b1) begin
            if (int'(ifc.win_x) > max_x) max_x = int'(ifc.win_x);
            if (int'(ifc.win_y) > max_y) max_y = int'(ifc.win_y);
         end
         if (r >= 2 && c >= 2) begin
            total++;
            if (ifc.win_valid !== 1'b1 || win_obs !== exp_win(16'h0, 1'b1, r, c)) begin
               bad++; $display("FAIL zcol_taps r=%0d c=%0d got=%h exp=%h", r, c, win_obs, exp_win(16'h0, 1'b1, r, c));
            end
         end
      end
      total++;
      if (max_x != W - 2 || max_y != H - 2) begin
         bad++; $display("FAIL zcol_extent got x=%0d y=%0d exp x=%0d y=%0d", max_x, max_y, W - 2, H - 2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.start     = 1'b0;
      ifc.pix_valid = 1'b0;
      ifc.pix_in    = '0;
      #2;
      test_reset;
      test_stream;
      test_gaps;
      test_back_to_back;
      test_start_truncate;
      test_start_idle;
      test_reset_mid;
      test_zero_column;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
